// File: rtl/racket_control_if.sv
// Frame-rate signal bundle between the video/ball logic and the racket controller.
// Clock and reset stay outside the interface as plain ports.
interface racket_control_if;
  logic        end_of_frame;
  logic        p1_up;
  logic        p1_down;
  logic        p2_up;
  logic        p2_down;
  logic        screen_idle;
  logic        screen_single;
  logic        screen_multi;
  logic [10:0] y_pos_of_ball;
  logic [9:0]  pos_of_player_1;
  logic [9:0]  pos_of_player_2;

  modport master (
    output end_of_frame, p1_up, p1_down, p2_up, p2_down,
           screen_idle, screen_single, screen_multi, y_pos_of_ball,
    input  pos_of_player_1, pos_of_player_2
  );

  modport slave (
    input  end_of_frame, p1_up, p1_down, p2_up, p2_down,
           screen_idle, screen_single, screen_multi, y_pos_of_ball,
    output pos_of_player_1, pos_of_player_2
  );
endinterface

// File: rtl/racket_control.sv
// Racket position controller: button-driven accelerating rackets, ball-tracking AI
// for racket 2 in single-player mode, re-centring on the idle screen.
module racket_control #(
  parameter int SCREEN_HEIGHT = 768,
  parameter int RACKET_HEIGHT = 80,
  parameter int BALL_SIZE     = 15,
  parameter int MIN_SPEED     = 2,
  parameter int MAX_SPEED     = 8,
  parameter int ACCEL_FRAMES  = 4,
  parameter int AI_SPEED      = 4,
  parameter int AI_DEADBAND   = 8
) (
  input  logic             clk65MHz,
  input  logic             rst_n,
  racket_control_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(ACCEL_FRAMES + 1);

  localparam logic [10:0]      POS_MAX  = 11'(SCREEN_HEIGHT - RACKET_HEIGHT);
  localparam logic [9:0]       CENTER   = 10'((SCREEN_HEIGHT - RACKET_HEIGHT) / 2);
  localparam logic [10:0]      MIN_SPD  = 11'(MIN_SPEED);
  localparam logic [10:0]      MAX_SPD  = 11'(MAX_SPEED);
  localparam logic [10:0]      AI_SPD   = 11'(AI_SPEED);
  localparam logic [10:0]      AI_DB    = 11'(AI_DEADBAND);
  localparam logic [10:0]      HALF_RKT = 11'(RACKET_HEIGHT / 2);
  localparam logic [10:0]      HALF_BAL = 11'(BALL_SIZE / 2);
  localparam logic [CNT_W-1:0] ACC_LAST = CNT_W'(ACCEL_FRAMES);

  typedef enum logic [1:0] {STOP, MOVE_UP, MOVE_DOWN} dir_t;

  typedef struct packed {
    dir_t             st;
    logic [10:0]      spd;
    logic [CNT_W-1:0] cnt;
    logic [9:0]       pos;
  } racket_t;

  localparam racket_t RACKET_RST = '{st: STOP, spd: MIN_SPD, cnt: '0, pos: CENTER};

  function automatic logic [9:0] step_up(input logic [9:0] pos, input logic [10:0] spd);
    logic [10:0] p;
    p = {1'b0, pos};
    return (p < spd) ? '0 : 10'(p - spd);
  endfunction

  function automatic logic [9:0] step_down(input logic [9:0] pos, input logic [10:0] spd);
    logic [10:0] p;
    p = {1'b0, pos} + spd;
    return (p > POS_MAX) ? 10'(POS_MAX) : 10'(p);
  endfunction

  // One frame of the button FSM; a direction change or a start from STOP restarts the ramp.
  function automatic racket_t btn_step(input racket_t r, input logic up, input logic down);
    racket_t          n;
    dir_t             want;
    logic [10:0]      s;
    logic [CNT_W-1:0] c;
    n = r;
    if (up && !down)
      want = MOVE_UP;
    else if (down && !up)
      want = MOVE_DOWN;
    else
      want = STOP;

    if (want == STOP) begin
      n.st  = STOP;
      n.spd = MIN_SPD;
      n.cnt = '0;
    end else begin
      s = (r.st == want) ? r.spd : MIN_SPD;
      c = (r.st == want) ? r.cnt : '0;
      n.pos = (want == MOVE_UP) ? step_up(r.pos, s) : step_down(r.pos, s);
      c = c + CNT_W'(1);
      if (c == ACC_LAST) begin
        c = '0;
        s = (s >= MAX_SPD) ? MAX_SPD : s + 11'd1;
      end
      n.st  = want;
      n.spd = s;
      n.cnt = c;
    end
    return n;
  endfunction

  logic [3:0] sync_a;
  logic [3:0] sync_b;
  logic [3:0] btn_raw;

  racket_t r1;
  racket_t r2;
  racket_t r1_btn;
  racket_t r2_btn;
  racket_t r2_ai;

  logic [10:0] rc;
  logic [10:0] bc;
  logic [9:0]  ai_pos;

  assign btn_raw = {bus.p2_down, bus.p2_up, bus.p1_down, bus.p1_up};

  always_comb begin
    r1_btn = btn_step(r1, sync_b[0], sync_b[1]);
    r2_btn = btn_step(r2, sync_b[2], sync_b[3]);

    rc     = {1'b0, r2.pos} + HALF_RKT;
    bc     = bus.y_pos_of_ball + HALF_BAL;
    ai_pos = r2.pos;
    if (bc < rc - AI_DB)
      ai_pos = step_up(r2.pos, AI_SPD);
    else if (bc > rc + AI_DB)
      ai_pos = step_down(r2.pos, AI_SPD);
    r2_ai = '{st: STOP, spd: MIN_SPD, cnt: '0, pos: ai_pos};
  end

  always_ff @(posedge clk65MHz or negedge rst_n) begin
    if (!rst_n) begin
      sync_a <= '0;
      sync_b <= '0;
      r1     <= RACKET_RST;
      r2     <= RACKET_RST;
    end else begin
      sync_a <= btn_raw;
      sync_b <= sync_a;
      if (bus.end_of_frame) begin
        if (bus.screen_idle) begin
          r1 <= RACKET_RST;
          r2 <= RACKET_RST;
        end else if (bus.screen_single) begin
          r1 <= r1_btn;
          r2 <= r2_ai;
        end else if (bus.screen_multi) begin
          r1 <= r1_btn;
          r2 <= r2_btn;
        end
      end
    end
  end

  assign bus.pos_of_player_1 = r1.pos;
  assign bus.pos_of_player_2 = r2.pos;

endmodule

// File: tb/tb_racket_control.sv
// Directed bench for racket_control: a frame-level reference model pushes expected
// positions to a scoreboard which is popped after each end_of_frame edge.
module tb_racket_control;

  logic clk65MHz = 1'b0;
  logic rst_n    = 1'b0;

  racket_control_if bus();

  racket_control #(
    .SCREEN_HEIGHT(768), .RACKET_HEIGHT(80), .BALL_SIZE(15), .MIN_SPEED(2),
    .MAX_SPEED(8), .ACCEL_FRAMES(4), .AI_SPEED(4), .AI_DEADBAND(8)
  ) dut (
    .clk65MHz (clk65MHz),
    .rst_n    (rst_n),
    .bus      (bus)
  );

  always #5 clk65MHz = ~clk65MHz;

  int total = 0;
  int fails = 0;

  // reference model: position, direction (-1 up, +1 down, 0 stop), speed, frame count
  int mp[2];
  int md[2];
  int mv[2];
  int mc[2];

  int exp_q1[$];
  int exp_q2[$];

  task automatic chk(input string tag, input logic [9:0] obs, input int expv);
    total++;
    assert (obs === 10'(expv))
    else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic int clamp(input int p);
    if (p < 0) return 0;
    if (p > 688) return 688;
    return p;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 2; i++) begin
      mp[i] = 344; md[i] = 0; mv[i] = 2; mc[i] = 0;
    end
  endtask

  task automatic m_btn(input int i, input logic u, input logic d);
    int dir;
    dir = (u && !d) ? -1 : ((d && !u) ? 1 : 0);
    if (dir == 0) begin
      md[i] = 0; mv[i] = 2; mc[i] = 0;
    end else begin
      if (md[i] != dir) begin
        mv[i] = 2; mc[i] = 0;
      end
      mp[i] = clamp(mp[i] + dir * mv[i]);
      mc[i]++;
      if (mc[i] == 4) begin
        mc[i] = 0;
        if (mv[i] < 8) mv[i]++;
      end
      md[i] = dir;
    end
  endtask

  task automatic m_ai();
    int rc, bc;
    rc = mp[1] + 40;
    bc = int'(bus.y_pos_of_ball) + 7;
    if (bc < rc - 8)      mp[1] = clamp(mp[1] - 4);
    else if (bc > rc + 8) mp[1] = clamp(mp[1] + 4);
    md[1] = 0; mv[1] = 2; mc[1] = 0;
  endtask

  task automatic m_frame_push();
    if (bus.screen_idle) begin
      m_reset();
    end else if (bus.screen_single) begin
      m_btn(0, bus.p1_up, bus.p1_down);
      m_ai();
    end else if (bus.screen_multi) begin
      m_btn(0, bus.p1_up, bus.p1_down);
      m_btn(1, bus.p2_up, bus.p2_down);
    end
    exp_q1.push_back(mp[0]);
    exp_q2.push_back(mp[1]);
  endtask

  task automatic pop_check(input string tag);
    int e1, e2;
    if (exp_q1.size() == 0 || exp_q2.size() == 0) begin
      total++; fails++;
      $error("FAIL %s_scoreboard observed=empty expected=entry", tag);
    end else begin
      e1 = exp_q1.pop_front();
      e2 = exp_q2.pop_front();
      chk({tag, "_p1"}, bus.pos_of_player_1, e1);
      chk({tag, "_p2"}, bus.pos_of_player_2, e2);
    end
  endtask

  // buttons settle through the synchroniser before the pulse
  task automatic frame(input string tag);
    repeat (3) @(negedge clk65MHz);
    bus.end_of_frame = 1'b1;
    m_frame_push();
    @(posedge clk65MHz);
    #1;
    pop_check(tag);
    @(negedge clk65MHz);
    bus.end_of_frame = 1'b0;
  endtask

  task automatic frames(input int n, input string tag);
    for (int k = 0; k < n; k++) frame(tag);
  endtask

  task automatic set_btn(input logic a, input logic b, input logic c, input logic d);
    bus.p1_up = a; bus.p1_down = b; bus.p2_up = c; bus.p2_down = d;
  endtask

  task automatic set_mode(input logic idle, input logic single, input logic multi);
    bus.screen_idle = idle; bus.screen_single = single; bus.screen_multi = multi;
  endtask

  initial begin
    int guard;
    set_btn(0, 0, 0, 0);
    set_mode(0, 0, 0);
    bus.end_of_frame  = 1'b0;
    bus.y_pos_of_ball = 11'd377;
    m_reset();

    #12;
    chk("reset_p1", bus.pos_of_player_1, 344);
    chk("reset_p2", bus.pos_of_player_2, 344);
    @(negedge clk65MHz);
    rst_n = 1'b1;

    set_mode(0, 0, 1);
    frame("multi_still");

    set_btn(1, 0, 0, 0);
    frames(10, "accel");
    chk("accel_end", bus.pos_of_player_1, 316);

    // asynchronous reset mid-motion, then a pulse that must be ignored
    set_btn(1, 0, 0, 1);
    frames(2, "pre_reset");
    @(negedge clk65MHz);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_p1", bus.pos_of_player_1, 344);
    chk("async_reset_p2", bus.pos_of_player_2, 344);
    m_reset();
    @(negedge clk65MHz);
    bus.end_of_frame = 1'b1;
    @(posedge clk65MHz);
    #1;
    chk("eof_in_reset_p1", bus.pos_of_player_1, 344);
    chk("eof_in_reset_p2", bus.pos_of_player_2, 344);
    @(negedge clk65MHz);
    bus.end_of_frame = 1'b0;
    set_btn(0, 0, 0, 0);
    rst_n = 1'b1;
    frames(2, "post_reset");

    // drive racket 1 down until it sits at 684, then restart the ramp into the limit
    set_btn(0, 1, 0, 0);
    guard = 0;
    while (mp[0] < 684 && guard < 100) begin
      frame("to_684");
      guard++;
    end
    chk("at_684", bus.pos_of_player_1, 684);
    set_btn(0, 0, 0, 0);
    frame("release_low");
    set_btn(0, 1, 0, 0);
    frame("clamp_low_a");
    chk("clamp_686", bus.pos_of_player_1, 686);
    frame("clamp_low_b");
    chk("clamp_688", bus.pos_of_player_1, 688);
    frame("clamp_low_c");
    chk("clamp_688_hold", bus.pos_of_player_1, 688);

    set_btn(1, 0, 0, 0);
    guard = 0;
    while (mp[0] > 0 && guard < 200) begin
      frame("to_top");
      guard++;
    end
    set_btn(0, 1, 0, 0);
    frames(5, "down5");
    chk("at_11", bus.pos_of_player_1, 11);
    set_btn(0, 0, 0, 0);
    frame("rel_a");
    set_btn(1, 0, 0, 0);
    frames(4, "up4");
    set_btn(0, 0, 0, 0);
    frame("rel_b");
    set_btn(1, 0, 0, 0);
    frame("to_1");
    chk("at_1", bus.pos_of_player_1, 1);
    frame("clamp_top_a");
    chk("clamp_0", bus.pos_of_player_1, 0);
    frame("clamp_top_b");
    chk("clamp_0_hold", bus.pos_of_player_1, 0);

    // racket 2: both buttons, then reversal after six frames
    set_btn(0, 0, 1, 1);
    frames(2, "both");
    chk("both_hold", bus.pos_of_player_2, 344);
    set_btn(0, 0, 1, 0);
    frames(6, "p2_up6");
    set_btn(0, 0, 0, 1);
    frame("reverse");
    chk("reverse_step", bus.pos_of_player_2, 332);

    // adjacent pulses are two full frames
    repeat (3) @(negedge clk65MHz);
    bus.end_of_frame = 1'b1;
    m_frame_push();
    @(posedge clk65MHz);
    #1;
    pop_check("b2b_first");
    m_frame_push();
    @(posedge clk65MHz);
    #1;
    pop_check("b2b_second");
    @(negedge clk65MHz);
    bus.end_of_frame = 1'b0;

    set_mode(0, 0, 0);
    set_btn(0, 1, 1, 0);
    frames(2, "no_mode");

    // AI tracking from centre
    set_mode(1, 0, 0);
    frame("idle_a");
    chk("idle_center_p1", bus.pos_of_player_1, 344);
    set_mode(0, 1, 0);
    set_btn(0, 0, 0, 0);
    bus.y_pos_of_ball = 11'd100;
    frame("ai_up");
    chk("ai_up_340", bus.pos_of_player_2, 340);
    set_mode(1, 0, 0);
    frame("idle_b");
    set_mode(0, 1, 0);
    bus.y_pos_of_ball = 11'd377;
    frame("ai_hold");
    chk("ai_hold_344", bus.pos_of_player_2, 344);
    set_mode(1, 0, 0);
    frame("idle_c");
    set_mode(0, 1, 0);
    bus.y_pos_of_ball = 11'd400;
    frame("ai_down");
    chk("ai_down_348", bus.pos_of_player_2, 348);
    set_btn(0, 0, 1, 0);
    frame("ai_btn_a");
    set_btn(0, 0, 0, 1);
    frame("ai_btn_b");
    set_btn(0, 0, 1, 1);
    frame("ai_btn_c");

    // push rackets to opposite limits, then idle with buttons held
    bus.y_pos_of_ball = 11'd2000;
    set_btn(1, 0, 1, 0);
    guard = 0;
    while ((mp[0] > 0 || mp[1] < 688) && guard < 200) begin
      frame("to_limits");
      guard++;
    end
    chk("limit_p1", bus.pos_of_player_1, 0);
    chk("limit_p2", bus.pos_of_player_2, 688);
    set_mode(1, 0, 0);
    set_btn(0, 1, 1, 0);
    frame("idle_recentre");
    chk("recentre_p1", bus.pos_of_player_1, 344);
    chk("recentre_p2", bus.pos_of_player_2, 344);
    frame("idle_buttons");

    // single then multi: racket 2 resumes from its AI position with a fresh ramp
    set_mode(0, 1, 0);
    set_btn(0, 0, 0, 0);
    bus.y_pos_of_ball = 11'd100;
    frames(3, "ai_walk");
    set_mode(0, 0, 1);
    set_btn(0, 0, 1, 0);
    frame("switch_multi");
    chk("switch_multi_p2", bus.pos_of_player_2, 330);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
